// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI receive path: receiver state codes,
// the dc flag encodings and the bit positions of the CPU read word.
// The TX driver and the CPU-side decode import the same names.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_PUSH  = 2'd2
  } rx_state_t;

  localparam logic SPI_DATA = 1'b0;
  localparam logic SPI_CMD  = 1'b1;

  localparam int RX_VALID_BIT = 10;
  localparam int RX_OVR_BIT   = 11;
  localparam int RX_FERR_BIT  = 12;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small first-word-fall-through receive FIFO used by spi_rx when the
// SPI_RX_FIFO_EN build option is defined. The caller only asserts push
// when there is room (after any same-cycle pop) and pop when not empty.
module spi_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Storage, pointers and occupancy; memory is cleared so dout reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver: synchronizes sck/sdi/cs_/dc, deserializes MSB-first
// frames and buffers {dc, byte} words for a memory-mapped CPU read port.
// Build option SPI_RX_FIFO_EN: when defined the buffer is a FIFO_DEPTH-entry
// FIFO (spi_rx_fifo); otherwise it is a single holding register.
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            sdi,
  input  logic            cs_,
  input  logic            dc,
  input  logic            rd,
  input  logic            clr,
  output logic [DATA_W:0] dout,
  output logic            valid,
  output logic            ovr,
  output logic            ferr,
  output logic [31:0]     rdata
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic sck_s, sdi_s, cs_s, dc_s, sck_d, rise;

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              dc_lat;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   push_data;

  // Synchronizers for the asynchronous pins; reset loads the idle bus levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      sdi_sync <= '0;
      dc_sync  <= '0;
      sck_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], dc};
      sck_d    <= sck_s;
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];
  assign dc_s  = dc_sync[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_d;

  // Frame FSM: shift on sck rises, hand a full frame to the buffer, flag frames cut short by cs_.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RX_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      dc_lat <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (clr) begin
        ferr <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!cs_s) begin
            state <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (cs_s) begin
            if (cnt != '0) begin
              ferr <= 1'b1;
            end
            cnt   <= '0;
            state <= RX_IDLE;
          end else if (rise) begin
            shreg <= {shreg[DATA_W-2:0], sdi_s};
            cnt   <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              dc_lat <= dc_s;
              state  <= RX_PUSH;
            end
          end
        end
        RX_PUSH: begin
          cnt   <= '0;
          state <= cs_s ? RX_IDLE : RX_SHIFT;
        end
        default: begin
          cnt   <= '0;
          state <= RX_IDLE;
        end
      endcase
    end
  end

  assign push      = (state == RX_PUSH);
  assign push_data = {dc_lat, shreg};
  assign pop       = rd & valid;

`ifdef SPI_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_full;
  logic fifo_push;

  assign fifo_push = push & (~fifo_full | pop);

  spi_rx_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .din   (push_data),
    .dout  (dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign valid = ~fifo_empty;

  // Overrun flag: a push that still finds the FIFO full after any same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovr <= 1'b1;
    end else if (clr) begin
      ovr <= 1'b0;
    end
  end
`else
  logic [DATA_W:0] hold_q;
  logic            hold_valid;

  // Single holding register: a same-cycle pop frees it for the push, otherwise a push while full overruns.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      if (clr) begin
        ovr <= 1'b0;
      end
      if (push) begin
        if (hold_valid && !pop) begin
          ovr <= 1'b1;
        end else begin
          hold_q     <= push_data;
          hold_valid <= 1'b1;
        end
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign dout  = hold_q;
  assign valid = hold_valid;
`endif

  // CPU read word: status bits above the {dc, byte} data field.
  always_comb begin
    rdata               = '0;
    rdata[DATA_W:0]     = dout;
    rdata[RX_VALID_BIT] = valid;
    rdata[RX_OVR_BIT]   = ovr;
    rdata[RX_FERR_BIT]  = ferr;
  end

endmodule

// File: tb/tb_spi_rx.sv
// Directed testbench for spi_rx. Acts as the SPI master with a 25-clk sck
// half-period; checks both the default build and the SPI_RX_FIFO_EN build.
module tb_spi_rx;
  import spi_rx_pkg::*;

  logic        clk;
  logic        reset;
  logic        sck, sdi, cs_, dc, rd, clr;
  logic [8:0]  dout;
  logic        valid, ovr, ferr;
  logic [31:0] rdata;

  int checks = 0;
  int passes = 0;

  spi_rx dut (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .sdi   (sdi),
    .cs_   (cs_),
    .dc    (dc),
    .rd    (rd),
    .clr   (clr),
    .dout  (dout),
    .valid (valid),
    .ovr   (ovr),
    .ferr  (ferr),
    .rdata (rdata)
  );

  // 62.5 MHz system clock
  initial clk = 1'b0;
  always #8 clk = ~clk;

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift out the top nbits of a frame MSB first; optionally pulse rd in the push cycle of the frame
  task automatic applyStimulus(input logic [7:0] data, input logic dcv, input int nbits, input bit rd_at_push);
    dc = dcv;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sck = 1'b0;
      sdi = data[7-i];
      waitClocks(25);
      sck = 1'b1;
      if (rd_at_push && i == 7) begin
        waitClocks(3);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        waitClocks(20);
      end else begin
        waitClocks(24);
      end
    end
  endtask

  task automatic pulseRd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic selectSlave(input logic level);
    @(negedge clk);
    cs_ = level;
    waitClocks(10);
  endtask

  initial begin
    reset = 1'b1;
    sck   = 1'b1;
    sdi   = 1'b0;
    cs_   = 1'b1;
    dc    = 1'b0;
    rd    = 1'b0;
    clr   = 1'b0;
    waitClocks(4);
    reset = 1'b0;
    waitClocks(2);

    checkOutput("reset valid", 32'(valid), 32'h0);
    checkOutput("reset dout", 32'(dout), 32'h0);
    checkOutput("reset ovr", 32'(ovr), 32'h0);
    checkOutput("reset ferr", 32'(ferr), 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);

    $display("[TB] single frame A5 with dc=1");
    selectSlave(1'b0);
    applyStimulus(8'hA5, SPI_CMD, 8, 1'b0);
    selectSlave(1'b1);
    checkOutput("t1 valid", 32'(valid), 32'h1);
    checkOutput("t1 dout", 32'(dout), 32'h1A5);
    checkOutput("t1 rdata", rdata, 32'h0000_05A5);
    pulseRd();
    checkOutput("t1 valid after rd", 32'(valid), 32'h0);

    $display("[TB] two frames 3C / C3 under one chip select");
    selectSlave(1'b0);
    applyStimulus(8'h3C, SPI_DATA, 8, 1'b0);
    applyStimulus(8'hC3, SPI_CMD, 8, 1'b0);
    selectSlave(1'b1);
`ifdef SPI_RX_FIFO_EN
    checkOutput("t2 first dout", 32'(dout), 32'h03C);
    checkOutput("t2 ovr", 32'(ovr), 32'h0);
    pulseRd();
    checkOutput("t2 second dout", 32'(dout), 32'h1C3);
    checkOutput("t2 second valid", 32'(valid), 32'h1);
    pulseRd();
    checkOutput("t2 drained", 32'(valid), 32'h0);
`else
    checkOutput("t2 dout kept", 32'(dout), 32'h03C);
    checkOutput("t2 ovr", 32'(ovr), 32'h1);
    checkOutput("t2 rdata", rdata, 32'h0000_0C3C);
    pulseRd();
    checkOutput("t2 drained", 32'(valid), 32'h0);
    pulseClr();
    checkOutput("t2 ovr cleared", 32'(ovr), 32'h0);
`endif

    $display("[TB] frame cut short after five bits");
    selectSlave(1'b0);
    applyStimulus(8'hF0, SPI_DATA, 5, 1'b0);
    selectSlave(1'b1);
    checkOutput("t3 ferr", 32'(ferr), 32'h1);
    checkOutput("t3 valid unchanged", 32'(valid), 32'h0);
    selectSlave(1'b0);
    applyStimulus(8'h01, SPI_DATA, 8, 1'b0);
    selectSlave(1'b1);
    checkOutput("t3 dout", 32'(dout), 32'h001);
    checkOutput("t3 rdata", rdata, 32'h0000_1401);
    pulseClr();
    checkOutput("t3 ferr cleared", 32'(ferr), 32'h0);
    pulseRd();
    checkOutput("t3 drained", 32'(valid), 32'h0);

`ifdef SPI_RX_FIFO_EN
    $display("[TB] five frames into a four-entry FIFO");
    selectSlave(1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h10 + 8'(i), SPI_DATA, 8, 1'b0);
    end
    selectSlave(1'b1);
    checkOutput("t4 ovr", 32'(ovr), 32'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4 head", 32'(dout), 32'h010 + 32'(i));
      pulseRd();
    end
    checkOutput("t4 drained", 32'(valid), 32'h0);
    pulseClr();
    checkOutput("t4 ovr cleared", 32'(ovr), 32'h0);
`endif

    $display("[TB] pop in the push cycle of a second frame");
    selectSlave(1'b0);
    applyStimulus(8'h55, SPI_DATA, 8, 1'b0);
    applyStimulus(8'hAA, SPI_CMD, 8, 1'b1);
    selectSlave(1'b1);
    checkOutput("t5 ovr", 32'(ovr), 32'h0);
    checkOutput("t5 valid", 32'(valid), 32'h1);
    checkOutput("t5 dout", 32'(dout), 32'h1AA);
    pulseRd();
    checkOutput("t5 drained", 32'(valid), 32'h0);

    $display("[TB] reset in the middle of a frame");
    selectSlave(1'b0);
    applyStimulus(8'hFF, SPI_DATA, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    waitClocks(3);
    reset = 1'b0;
    waitClocks(5);
    applyStimulus(8'h7E, SPI_DATA, 8, 1'b0);
    selectSlave(1'b1);
    checkOutput("t6 dout", 32'(dout), 32'h07E);
    checkOutput("t6 valid", 32'(valid), 32'h1);
    checkOutput("t6 ferr", 32'(ferr), 32'h0);
    checkOutput("t6 ovr", 32'(ovr), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
